// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, constraint-length-7 convolutional encoder.
// Bytes are encoded MSB first, one symbol pair per accepted bit. A frame ends
// with 6 zero tail bits that return the shift register to zero.
// A one-byte holding buffer lets the next byte start without a gap.
// The output pair is registered and held stable while the sink stalls.
// Optional macro CONV_ENC_SOFT_EN: emits signed soft symbols (+M for bit 0,
// -M for bit 1, M = 2^(SOFT_WIDTH-1)-1) instead of the 2-bit hard pair.
module conv_encoder #(
  parameter logic [6:0] POLY_G1    = 7'b1111001,
  parameter logic [6:0] POLY_G2    = 7'b1011011,
  parameter int         SOFT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic [7:0]              data_in,
  input  logic                    valid_in,
  input  logic                    last_in,
  output logic                    in_ready,
`ifdef CONV_ENC_SOFT_EN
  output logic [2*SOFT_WIDTH-1:0] sym_out,
`else
  output logic [1:0]              sym_out,
`endif
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    sym_last,
  output logic                    busy
);

  if (SOFT_WIDTH < 2) begin : g_bad_soft_width
    $error("conv_encoder: SOFT_WIDTH must be at least 2");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENCODE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [1:0] state;
  logic [5:0] sr;         // sr[5] is the most recent bit
  logic [7:0] cur;        // byte being encoded
  logic       cur_last;
  logic [2:0] bit_idx;    // index of the next bit of cur to emit
  logic [2:0] tail_cnt;   // tail pairs already emitted
  logic [7:0] hold;       // holding buffer
  logic       hold_full;
  logic       hold_last;

  logic       acc;        // byte accepted this cycle
  logic       adv;        // output register may take a new pair
  logic       emit;
  logic       emit_bit;
  logic       emit_last;
  logic       idle_start; // IDLE -> ENCODE, emitting bit 7 now
  logic       reload;     // ENCODE continues into the buffered byte
  logic       direct;     // accepted byte is consumed without buffering
  logic       load;
  logic       drain;
  logic [7:0] start_byte;
  logic       start_last;
  logic [6:0] w;
  logic       g1;
  logic       g2;

  assign in_ready   = !hold_full && (state != ST_FLUSH);
  assign acc        = valid_in && in_ready;
  assign adv        = !sym_valid || sym_ready;
  assign busy       = (state != ST_IDLE) || hold_full;
  assign start_byte = hold_full ? hold : data_in;
  assign start_last = hold_full ? hold_last : last_in;

  // Decide what the output register receives this cycle.
  always_comb begin
    emit       = 1'b0;
    emit_bit   = 1'b0;
    emit_last  = 1'b0;
    idle_start = 1'b0;
    reload     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (adv && (hold_full || acc)) begin
          idle_start = 1'b1;
          emit       = 1'b1;
          emit_bit   = start_byte[7];
        end
      end
      ST_ENCODE: begin
        if (adv) begin
          emit     = 1'b1;
          emit_bit = cur[bit_idx];
          reload   = (bit_idx == 3'd0) && !cur_last && hold_full;
        end
      end
      ST_FLUSH: begin
        if (adv) begin
          emit      = 1'b1;
          emit_last = (tail_cnt == 3'd5);
        end
      end
      default: ;
    endcase
  end

  assign direct = idle_start && !hold_full;
  assign load   = acc && !direct;
  assign drain  = (idle_start && hold_full) || reload;

  assign w  = {emit_bit, sr};
  assign g1 = ^(w & POLY_G1);
  assign g2 = ^(w & POLY_G2);

`ifdef CONV_ENC_SOFT_EN
  localparam logic [SOFT_WIDTH-1:0] SOFT_POS = {1'b0, {(SOFT_WIDTH-1){1'b1}}};
  localparam logic [SOFT_WIDTH-1:0] SOFT_NEG = {1'b1, {(SOFT_WIDTH-2){1'b0}}, 1'b1};
  logic [2*SOFT_WIDTH-1:0] pair_val;
  assign pair_val = {g1 ? SOFT_NEG : SOFT_POS, g2 ? SOFT_NEG : SOFT_POS};
`else
  logic [1:0] pair_val;
  assign pair_val = {g1, g2};
`endif

  // Registered output pair; held while the sink stalls.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
      sym_out   <= '0;
      sr        <= '0;
    end else if (adv) begin
      sym_valid <= emit;
      sym_last  <= emit_last;
      if (emit) begin
        sym_out <= pair_val;
        sr      <= w[6:1];
      end
    end
  end

  // Frame sequencing: IDLE / ENCODE / FLUSH with bit and tail counters.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      cur      <= '0;
      cur_last <= 1'b0;
      bit_idx  <= '0;
      tail_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idle_start) begin
            cur      <= start_byte;
            cur_last <= start_last;
            bit_idx  <= 3'd6;
            state    <= ST_ENCODE;
          end
        end
        ST_ENCODE: begin
          if (adv) begin
            if (bit_idx == 3'd0) begin
              if (cur_last) begin
                state    <= ST_FLUSH;
                tail_cnt <= '0;
              end else if (hold_full) begin
                cur      <= hold;
                cur_last <= hold_last;
                bit_idx  <= 3'd7;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              bit_idx <= bit_idx - 3'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (adv) begin
            if (tail_cnt == 3'd5) begin
              tail_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              tail_cnt <= tail_cnt + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Holding buffer; a load in the same cycle as a drain keeps the new byte.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      hold      <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold      <= data_in;
      hold_last <= last_in;
      hold_full <= 1'b1;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: expected pairs come from a frame-level
// convolution model; a monitor compares every handed-off pair and checks that
// the output holds during stalls. Literal checks pin the model.
module tb_conv_encoder;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b1011011;
  localparam int SW = 8;
`ifdef CONV_ENC_SOFT_EN
  localparam int OW = 2*SW;
`else
  localparam int OW = 2;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [7:0]    data_in = '0;
  logic          valid_in = 1'b0;
  logic          last_in = 1'b0;
  logic          in_ready;
  logic [OW-1:0] sym_out;
  logic          sym_valid;
  logic          sym_ready = 1'b1;
  logic          sym_last;
  logic          busy;

  conv_encoder #(.POLY_G1(G1), .POLY_G2(G2), .SOFT_WIDTH(SW)) dut (
    .clk(clk), .sys_rst(sys_rst), .data_in(data_in), .valid_in(valid_in),
    .last_in(last_in), .in_ready(in_ready), .sym_out(sym_out),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_last(sym_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_hand = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic [2:0] exp_q[$];   // {g1,g2,last}
  logic [2:0] got_q[$];
  int hand_cyc[$];
  logic          prev_stall = 1'b0;
  logic [OW-1:0] prev_out;
  logic          prev_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] to_out(input logic [1:0] p);
`ifdef CONV_ENC_SOFT_EN
    logic [SW-1:0] pos, neg;
    pos = 8'sd127;
    neg = -8'sd127;
    return {p[1] ? neg : pos, p[0] ? neg : pos};
`else
    return p;
`endif
  endfunction

  function automatic logic [1:0] from_out(input logic [OW-1:0] o);
`ifdef CONV_ENC_SOFT_EN
    return {o[2*SW-1], o[SW-1]};
`else
    return o;
`endif
  endfunction

  // Model: convolve the frame's bits (MSB first, plus 6 zero tail bits).
  task automatic push_frame(input bq_t b);
    int bits[$];
    int s, w, g1, g2;
    s = 0;
    foreach (b[i]) for (int k = 7; k >= 0; k--) bits.push_back(int'(b[i][k]));
    for (int t = 0; t < 6; t++) bits.push_back(0);
    for (int n = 0; n < bits.size(); n++) begin
      w  = (bits[n] << 6) | s;
      g1 = $countones(w & int'(G1)) % 2;
      g2 = $countones(w & int'(G2)) % 2;
      s  = w >> 1;
      exp_q.push_back({g1[0], g2[0], n == bits.size() - 1});
    end
  endtask

  // Sink ready pattern: always 1, or 1,0,0 repeating.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    sym_ready = (rdy_mode == 0) || (cyc % 3 == 0);
  end

  // Monitor: compare each handed-off pair, check stability while stalled.
  always @(negedge clk) begin
    logic [2:0] e;
    if (sys_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", sym_valid, 1);
        chk("stall_out", sym_out, prev_out);
        chk("stall_last", sym_last, prev_last);
      end
      if (sym_valid && sym_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_pair: got pair %0h expected none", sym_out);
        end else begin
          e = exp_q.pop_front();
          if (sym_out !== to_out(e[2:1]) || sym_last !== e[0]) begin
            n_err++;
            $display("FAIL pair: got %0h last %0b expected %0h last %0b",
                     sym_out, sym_last, to_out(e[2:1]), e[0]);
          end
        end
        got_q.push_back({from_out(sym_out), sym_last});
        hand_cyc.push_back(cyc);
        n_hand++;
      end
      prev_stall = sym_valid && !sym_ready;
      prev_out   = sym_out;
      prev_last  = sym_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || sym_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hand(input int n);
    int t;
    t = 0;
    while (n_hand < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("hand_timeout", n_hand >= n, 1);
  endtask

  task automatic start_frame(input bq_t fr);
    got_q.delete();
    hand_cyc.delete();
    n_hand = 0;
    push_frame(fr);
  endtask

  task automatic check_0x80(input string tag);
    logic [1:0] ref80 [7];
    ref80 = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    chk({tag, "_count"}, got_q.size(), 14);
    if (got_q.size() == 14) begin
      for (int i = 0; i < 7; i++) chk({tag, "_head"}, got_q[i][2:1], ref80[i]);
      for (int i = 7; i < 14; i++) chk({tag, "_tail"}, got_q[i][2:1], 0);
      for (int i = 0; i < 13; i++) chk({tag, "_nolast"}, got_q[i][0], 0);
      chk({tag, "_last"}, got_q[13][0], 1);
    end
  endtask

  initial begin
    bq_t fr;
    int nz;

    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", sym_valid, 0);
    chk("rst_last", sym_last, 0);
    chk("rst_out", sym_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 0x00 last: 14 zero pairs, in_ready low during tail.
    fr = '{8'h00};
    start_frame(fr);
    send(8'h00, 1'b1);
    wait_hand(10);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_busy", busy, 1);
    wait_drain();
    chk("zero_count", got_q.size(), 14);
    nz = 0;
    foreach (got_q[i]) if (got_q[i][2:1] != 2'b00) nz++;
    chk("zero_pairs", nz, 0);
    if (got_q.size() == 14) chk("zero_last", got_q[13][0], 1);

    // 0x80 last with ready high.
    fr = '{8'h80};
    start_frame(fr);
    send(8'h80, 1'b1);
    wait_drain();
    check_0x80("x80");

    // 0x80 last with ready toggling 1,0,0.
    rdy_mode = 1;
    start_frame(fr);
    send(8'h80, 1'b1);
    wait_drain();
    check_0x80("x80_stall");

    // Buffer full: a third byte offered while in_ready is low is ignored.
    fr = '{8'h12, 8'h34};
    start_frame(fr);
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    valid_in = 1'b1;
    data_in  = 8'h56;
    last_in  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    wait_drain();
    chk("full_count", got_q.size(), 22);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // 0xFF then 0x00 back-to-back: 22 pairs with no gaps.
    fr = '{8'hFF, 8'h00};
    start_frame(fr);
    send(8'hFF, 1'b0);
    send(8'h00, 1'b1);
    wait_drain();
    chk("b2b_count", got_q.size(), 22);
    if (got_q.size() == 22) begin
      chk("b2b_span", hand_cyc[21] - hand_cyc[0], 21);
      chk("b2b_pair7", got_q[6][2:1], 2'b11);
      chk("b2b_pair8", got_q[7][2:1], 2'b11);
      chk("b2b_last", got_q[21][0], 1);
      chk("b2b_nolast", got_q[20][0], 0);
    end

    // Reset after 3 pairs, then a clean 0x80 frame.
    fr = '{8'h80};
    start_frame(fr);
    send(8'h80, 1'b1);
    wait_hand(3);
    @(posedge clk);
    #1;
    sys_rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    sys_rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", sym_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_last", sym_last, 0);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1;
    start_frame(fr);
    send(8'h80, 1'b1);
    wait_drain();
    check_0x80("x80_after_rst");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 The block SHALL have parameter POLY_G1, default 7'b1111001 (octal 171), meaning the generator taps for the first symbol.
REQ-002 The block SHALL have parameter POLY_G2, default 7'b1011011 (octal 133), meaning the generator taps for the second symbol.
REQ-003 The block SHALL have parameter SOFT_WIDTH, default 8, meaning the soft symbol width; it is used only under CONV_ENC_SOFT_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports data_in (input, 8 bits, byte to encode) and valid_in (input, 1 bit, data_in valid).
REQ-007 The block SHALL have port last_in, input, 1 bit: marks the final byte of a frame.
REQ-008 The block SHALL have port in_ready, output, 1 bit: byte accepted when valid_in && in_ready.
REQ-009 The block SHALL have port sym_out, output, 2 bits {g1,g2}, or 2*SOFT_WIDTH bits {soft_g1,soft_g2} under CONV_ENC_SOFT_EN.
REQ-010 The block SHALL have ports sym_valid (output, 1), sym_ready (input, 1) and sym_last (output, 1, final tail pair of a frame).
REQ-011 The block SHALL have port busy, output, 1 bit: high when the block is not IDLE or the buffer is occupied.

Function
REQ-012 Encoding SHALL use window w[6:0] = {b, s[5:0]}, where b is the current bit and s[5] is the previous bit; g1 = ^(w & POLY_G1), g2 = ^(w & POLY_G2); next s = w[6:1].
REQ-013 Bits SHALL be taken MSB first; each input bit produces exactly one symbol pair.
REQ-014 FSM: IDLE -> ENCODE on byte acceptance; ENCODE -> FLUSH after bit 0 of a byte flagged last; ENCODE -> IDLE after bit 0 when the buffer is empty; FLUSH -> IDLE after 6 tail pairs are handed off.
REQ-015 A one-byte holding buffer SHALL exist: in_ready = !buffer_full; a byte may be accepted while ENCODE is running.
REQ-016 After bit 0 is handed off, a buffered byte SHALL begin in the next pair with no gap cycle.
REQ-017 FLUSH SHALL feed 6 zero bits, returning s to 0; sym_last SHALL be asserted only with the 6th tail pair.
REQ-018 in_ready SHALL be low during FLUSH, so that frames never overlap.
REQ-019 Latency: the first pair of a byte accepted in IDLE SHALL be valid in the cycle after acceptance.
REQ-020 Output is registered: while sym_valid && !sym_ready, sym_out, sym_last and the internal state SHALL hold stable.
REQ-021 The encoder SHALL advance exactly when sym_valid && sym_ready, or when no pair is pending.
REQ-022 With sym_ready held high, throughput SHALL be one pair per cycle, i.e. 8 cycles per byte.
REQ-023 A byte with valid_in arriving while in_ready is low SHALL be ignored; upstream holds it.
REQ-024 Simultaneous buffer load and buffer drain in one cycle SHALL retain the new byte.

Reset
REQ-025 On sys_rst, the block SHALL enter IDLE and clear s to 0, the buffer to empty and the bit/tail counters to 0.
REQ-026 On sys_rst, outputs SHALL be: sym_valid = 0, sym_last = 0, sym_out = 0, busy = 0, in_ready = 1 from the following cycle.
REQ-027 Reset mid-frame SHALL discard the frame with no tail and no sym_last; the next frame SHALL encode from s = 0.

Configuration
REQ-028 When macro CONV_ENC_SOFT_EN is defined, each symbol SHALL be mapped to signed SOFT_WIDTH: bit 0 -> +(2^(SOFT_WIDTH-1)-1), bit 1 -> -(2^(SOFT_WIDTH-1)-1) (+127/-127 at width 8).
REQ-029 When CONV_ENC_SOFT_EN is undefined, sym_out SHALL be the 2-bit hard pair; timing is identical in both modes.

Verification
REQ-030 Reset, 0x00 with last_in, sym_ready=1 -> 14 pairs, all 00; sym_last on pair 14 only.
REQ-031 Reset, 0x80 with last_in -> pairs 11,10,11,11,00,01,11 followed by seven 00 pairs; sym_last on pair 14.
REQ-032 Scenario REQ-031 with sym_ready toggled 1,0,0,1,... -> identical pair sequence; sym_out stable during every stall.
REQ-033 0xFF then 0x00 (last) offered back-to-back with sym_ready=1 -> 22 pairs with no gaps; pairs 7 and 8 = 11; sym_last on pair 22.
REQ-034 Assert sys_rst after 3 pairs of a frame -> sym_valid=0 the next cycle, in_ready=1; a following 0x80 frame reproduces REQ-031 exactly.
REQ-035 With CONV_ENC_SOFT_EN and SOFT_WIDTH=8, 0x80 with last_in -> first pair (-127,-127), second pair (-127,+127).
